// File: rtl/memory_bus_pkg.sv
// Shared CPU memory-bus definitions: bus command codes, responder state encoding
// and the address range helper used by the MAR/MDR/memory blocks.
package memory_bus_pkg;

  typedef logic [1:0] mem_mode_t;

  localparam mem_mode_t MEM_IDLE  = 2'b00;
  localparam mem_mode_t MEM_WRITE = 2'b01;
  localparam mem_mode_t MEM_READ  = 2'b10;
  localparam mem_mode_t MEM_HOLD  = 2'b11;

  typedef logic [1:0] resp_state_t;

  localparam resp_state_t ST_IDLE  = 2'd0;
  localparam resp_state_t ST_WACK  = 2'd1;
  localparam resp_state_t ST_RWAIT = 2'd2;
  localparam resp_state_t ST_DRIVE = 2'd3;

  localparam int MEM_DATA_WIDTH = 32;

  // True when no address bit at or above addr_bits is set.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_bits);
    return (addr >> addr_bits) == 32'd0;
  endfunction

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module memory_array #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // rdata only moves on a read so it stays stable while the responder waits.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Word-addressed memory answering MAR-driven requests on the shared tri-state data bus,
// with a fixed read latency and out-of-range detection.
module memory_responder
  import memory_bus_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mem_mode,
  input  logic [31:0]           address,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  output logic                  busy,
  output logic                  ready,
  output logic                  error
);

  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  resp_state_t           state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  error_reg;
  logic                  is_idle;
  logic                  addr_ok;
  logic                  accept_write;
  logic                  accept_read;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign addr_ok      = addr_in_range(address, ADDR_BITS);
  assign is_idle      = (state_reg == ST_IDLE);
  assign accept_write = is_idle && (mem_mode == MEM_WRITE);
  assign accept_read  = is_idle && (mem_mode == MEM_READ);

  memory_array #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clock (clock),
    .we    (accept_write && addr_ok),
    .re    (accept_read),
    .addr  (address[ADDR_BITS-1:0]),
    .wdata (data_bus),
    .rdata (ram_rdata)
  );

  // Reads always pass through RWAIT: the RAM word lands one edge after acceptance,
  // so RWAIT spends READ_LATENCY cycles before DRIVE presents it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        case (mem_mode)
          MEM_WRITE: state_next = ST_WACK;
          MEM_READ: begin
            state_next = ST_RWAIT;
            cnt_next   = CNT_LOAD;
          end
          MEM_IDLE, MEM_HOLD: state_next = ST_IDLE;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_WACK:  state_next = ST_IDLE;
      ST_RWAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = ST_DRIVE;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      ST_DRIVE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 2'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept_write || accept_read) begin
        error_reg <= !addr_ok;
      end
    end
  end

  assign busy  = !is_idle;
  assign ready = (state_reg == ST_WACK) || (state_reg == ST_DRIVE);
  assign error = error_reg;

  // Out-of-range reads return zeros; the bus is released whenever we are not in DRIVE.
  assign data_bus = (state_reg == ST_DRIVE) ? (error_reg ? '0 : ram_rdata) : 'z;

endmodule
